// File: rtl/nxn_tic_tac_toe_game.sv
// N x N tic-tac-toe referee: alternates player/computer moves, rejects illegal
// moves, detects wins/draws one cycle after each move and keeps saturating tallies.
`timescale 1ns/1ps
module nxn_tic_tac_toe_game #(
  parameter  int unsigned N       = 3,
  parameter  int unsigned TALLY_W = 8,
  localparam int unsigned IDXW    = $clog2(N*N),
  localparam int unsigned MCW     = $clog2(N*N+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 play,
  input  logic                 pc,
  input  logic                 new_game,
  input  logic [IDXW-1:0]      player_position,
  input  logic [IDXW-1:0]      computer_position,
  output logic [2*N*N-1:0]     board,
  output logic [1:0]           who,
  output logic                 game_over,
  output logic                 illegal_move,
  output logic                 turn,
  output logic [MCW-1:0]       move_count,
  output logic [TALLY_W-1:0]   player_wins,
  output logic [TALLY_W-1:0]   computer_wins,
  output logic [TALLY_W-1:0]   draws
);

  typedef enum logic [2:0] {
    PLAYER_TURN,
    CHECK_P,
    COMPUTER_TURN,
    CHECK_C,
    GAME_OVER
  } state_t;

  localparam logic [MCW-1:0] ALL_CELLS = MCW'(N*N);

  state_t               state_q, state_d;
  logic [2*N*N-1:0]     board_q, board_d;
  logic [1:0]           who_q, who_d;
  logic                 game_over_q, game_over_d;
  logic                 illegal_move_q, illegal_move_d;
  logic [MCW-1:0]       move_count_q, move_count_d;
  logic [TALLY_W-1:0]   player_wins_q, player_wins_d;
  logic [TALLY_W-1:0]   computer_wins_q, computer_wins_d;
  logic [TALLY_W-1:0]   draws_q, draws_d;

  logic                 mv_req;
  logic [IDXW-1:0]      mv_pos;
  logic [1:0]           mv_code;
  logic                 mv_legal;
  logic                 win_p, win_c;

  function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b,
                                         input logic [IDXW-1:0]  pos);
    logic [1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N*N; i++) begin
      if (32'(pos) == i) c = b[2*i +: 2];
    end
    return c;
  endfunction

  function automatic logic has_line(input logic [2*N*N-1:0] b,
                                    input logic [1:0]       code);
    logic hit, row_ok, col_ok, diag_ok, anti_ok;
    hit     = 1'b0;
    diag_ok = 1'b1;
    anti_ok = 1'b1;
    for (int unsigned r = 0; r < N; r++) begin
      row_ok = 1'b1;
      col_ok = 1'b1;
      for (int unsigned c = 0; c < N; c++) begin
        if (b[2*(r*N+c) +: 2] != code) row_ok = 1'b0;
        if (b[2*(c*N+r) +: 2] != code) col_ok = 1'b0;
      end
      hit = hit | row_ok | col_ok;
      if (b[2*(r*N+r) +: 2] != code)       diag_ok = 1'b0;
      if (b[2*(r*N+N-1-r) +: 2] != code)   anti_ok = 1'b0;
    end
    return hit | diag_ok | anti_ok;
  endfunction

  always_comb begin
    mv_req   = (state_q == PLAYER_TURN && play) || (state_q == COMPUTER_TURN && pc);
    mv_pos   = (state_q == PLAYER_TURN) ? player_position : computer_position;
    mv_code  = (state_q == PLAYER_TURN) ? 2'b01 : 2'b10;
    mv_legal = (32'(mv_pos) < N*N) && (cell_at(board_q, mv_pos) == 2'b00);
    win_p    = has_line(board_q, 2'b01);
    win_c    = has_line(board_q, 2'b10);
  end

  always_comb begin
    state_d         = state_q;
    board_d         = board_q;
    who_d           = who_q;
    game_over_d     = game_over_q;
    illegal_move_d  = 1'b0;
    move_count_d    = move_count_q;
    player_wins_d   = player_wins_q;
    computer_wins_d = computer_wins_q;
    draws_d         = draws_q;

    if (new_game) begin
      state_d      = PLAYER_TURN;
      board_d      = '0;
      who_d        = 2'b00;
      game_over_d  = 1'b0;
      move_count_d = '0;
    end else begin
      case (state_q)
        PLAYER_TURN, COMPUTER_TURN: begin
          if (mv_req) begin
            if (mv_legal) begin
              for (int unsigned i = 0; i < N*N; i++) begin
                if (32'(mv_pos) == i) board_d[2*i +: 2] = mv_code;
              end
              move_count_d = move_count_q + MCW'(1);
              state_d      = (state_q == PLAYER_TURN) ? CHECK_P : CHECK_C;
            end else begin
              illegal_move_d = 1'b1;
            end
          end
        end
        CHECK_P, CHECK_C: begin
          // Only the side that just moved can have completed a line.
          if (win_p) begin
            who_d       = 2'b01;
            game_over_d = 1'b1;
            state_d     = GAME_OVER;
            if (player_wins_q != '1) player_wins_d = player_wins_q + TALLY_W'(1);
          end else if (win_c) begin
            who_d       = 2'b10;
            game_over_d = 1'b1;
            state_d     = GAME_OVER;
            if (computer_wins_q != '1) computer_wins_d = computer_wins_q + TALLY_W'(1);
          end else if (move_count_q == ALL_CELLS) begin
            who_d       = 2'b11;
            game_over_d = 1'b1;
            state_d     = GAME_OVER;
            if (draws_q != '1) draws_d = draws_q + TALLY_W'(1);
          end else begin
            state_d = (state_q == CHECK_P) ? COMPUTER_TURN : PLAYER_TURN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= PLAYER_TURN;
      board_q         <= '0;
      who_q           <= '0;
      game_over_q     <= 1'b0;
      illegal_move_q  <= 1'b0;
      move_count_q    <= '0;
      player_wins_q   <= '0;
      computer_wins_q <= '0;
      draws_q         <= '0;
    end else begin
      state_q         <= state_d;
      board_q         <= board_d;
      who_q           <= who_d;
      game_over_q     <= game_over_d;
      illegal_move_q  <= illegal_move_d;
      move_count_q    <= move_count_d;
      player_wins_q   <= player_wins_d;
      computer_wins_q <= computer_wins_d;
      draws_q         <= draws_d;
    end
  end

  assign board         = board_q;
  assign who           = who_q;
  assign game_over     = game_over_q;
  assign illegal_move  = illegal_move_q;
  assign turn          = (state_q == COMPUTER_TURN) || (state_q == CHECK_P);
  assign move_count    = move_count_q;
  assign player_wins   = player_wins_q;
  assign computer_wins = computer_wins_q;
  assign draws         = draws_q;

endmodule

// File: tb/tb_nxn_tic_tac_toe_game.sv
// Bench for nxn_tic_tac_toe_game: directed scenarios plus random play, all
// compared every cycle against a game-rules reference model.
`timescale 1ns/1ps
module tb_nxn_tic_tac_toe_game;

  localparam int unsigned N       = 3;
  localparam int unsigned TALLY_W = 2;
  localparam int unsigned CELLS   = N*N;
  localparam int unsigned IDXW    = $clog2(CELLS);
  localparam int unsigned MCW     = $clog2(CELLS+1);
  localparam int          TMAX    = (1 << TALLY_W) - 1;

  logic                clock = 1'b0;
  logic                reset;
  logic                play, pc, new_game;
  logic [IDXW-1:0]     player_position, computer_position;
  logic [2*CELLS-1:0]  board;
  logic [1:0]          who;
  logic                game_over, illegal_move, turn;
  logic [MCW-1:0]      move_count;
  logic [TALLY_W-1:0]  player_wins, computer_wins, draws;

  nxn_tic_tac_toe_game #(.N(N), .TALLY_W(TALLY_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .play              (play),
    .pc                (pc),
    .new_game          (new_game),
    .player_position   (player_position),
    .computer_position (computer_position),
    .board             (board),
    .who               (who),
    .game_over         (game_over),
    .illegal_move      (illegal_move),
    .turn              (turn),
    .move_count        (move_count),
    .player_wins       (player_wins),
    .computer_wins     (computer_wins),
    .draws             (draws)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: the game as a referee would describe it.
  int mb[CELLS];
  int m_who, m_over, m_ill, m_mc, m_pw, m_cw, m_dr;
  int m_mover;     // 1 = player must move next, 2 = computer
  bit m_pending;   // a move was just placed and awaits judgement

  function automatic int winner();
    int idx, first;
    bit same;
    for (int l = 0; l < 2*N+2; l++) begin
      same = 1'b1;
      first = -1;
      for (int k = 0; k < N; k++) begin
        if (l < N)            idx = l*N + k;
        else if (l < 2*N)     idx = k*N + (l-N);
        else if (l == 2*N)    idx = k*N + k;
        else                  idx = k*N + (N-1-k);
        if (k == 0) first = mb[idx];
        else if (mb[idx] != first) same = 1'b0;
      end
      if (same && first != 0) return first;
    end
    return 0;
  endfunction

  task automatic model_clear_game();
    foreach (mb[i]) mb[i] = 0;
    m_who = 0; m_over = 0; m_mc = 0; m_mover = 1; m_pending = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_game();
    m_ill = 0; m_pw = 0; m_cw = 0; m_dr = 0;
  endtask

  task automatic model_step(input bit p, input bit c, input bit ng, input int pp, input int cp);
    int w, pos;
    bit req;
    m_ill = 0;
    if (ng) begin
      model_clear_game();
    end else if (m_over != 0) begin
    end else if (m_pending) begin
      m_pending = 1'b0;
      w = winner();
      if (w != 0) begin
        m_who = w; m_over = 1;
        if (w == 1 && m_pw < TMAX) m_pw++;
        if (w == 2 && m_cw < TMAX) m_cw++;
      end else if (m_mc == CELLS) begin
        m_who = 3; m_over = 1;
        if (m_dr < TMAX) m_dr++;
      end else begin
        m_mover = 3 - m_mover;
      end
    end else begin
      req = (m_mover == 1) ? p : c;
      pos = (m_mover == 1) ? pp : cp;
      if (req) begin
        if (pos >= CELLS || mb[pos] != 0) m_ill = 1;
        else begin
          mb[pos] = m_mover; m_mc++; m_pending = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] eb;
    int exp_turn;
    eb = '0;
    for (int i = 0; i < CELLS; i++) eb = eb | (64'(mb[i]) << (2*i));
    exp_turn = (m_over == 0 && ((m_mover == 2) != m_pending)) ? 1 : 0;
    check_eq("board",         64'(board),         eb);
    check_eq("who",           64'(who),           64'(m_who));
    check_eq("game_over",     64'(game_over),     64'(m_over));
    check_eq("illegal_move",  64'(illegal_move),  64'(m_ill));
    check_eq("turn",          64'(turn),          64'(exp_turn));
    check_eq("move_count",    64'(move_count),    64'(m_mc));
    check_eq("player_wins",   64'(player_wins),   64'(m_pw));
    check_eq("computer_wins", 64'(computer_wins), 64'(m_cw));
    check_eq("draws",         64'(draws),         64'(m_dr));
  endtask

  // Called at a falling edge: drive, advance the model, then check at the next falling edge.
  task automatic step(input bit p, input bit c, input bit ng, input int pp, input int cp);
    play = p; pc = c; new_game = ng;
    player_position   = IDXW'(pp);
    computer_position = IDXW'(cp);
    model_step(p, c, ng, pp, cp);
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle();          step(1'b0, 1'b0, 1'b0, 0, 0);   endtask
  task automatic start_game();    step(1'b0, 1'b0, 1'b1, 0, 0);   endtask
  task automatic pmove(input int pos); step(1'b1, 1'b0, 1'b0, pos, 0); idle(); endtask
  task automatic cmove(input int pos); step(1'b0, 1'b1, 1'b0, 0, pos); idle(); endtask

  task automatic row_win_game();
    start_game();
    pmove(0); cmove(3); pmove(1); cmove(4); pmove(2);
  endtask

  logic [TALLY_W-1:0] saved_pw;
  logic [1:0]         cell0;

  initial begin
    reset = 1'b0; play = 1'b0; pc = 1'b0; new_game = 1'b0;
    player_position = '0; computer_position = '0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset = 1'b1;
    idle();

    row_win_game();
    check_eq("row_win_who",  64'(who),         64'd1);
    check_eq("row_win_over", 64'(game_over),   64'd1);
    check_eq("row_win_pw",   64'(player_wins), 64'd1);
    check_eq("row_win_mc",   64'(move_count),  64'd5);
    step(1'b1, 1'b1, 1'b0, 5, 6);
    check_eq("over_hold_ill", 64'(illegal_move), 64'd0);

    start_game();
    pmove(0); cmove(4); pmove(1);
    step(1'b0, 1'b1, 1'b0, 0, 4);
    check_eq("occupied_ill",  64'(illegal_move), 64'd1);
    check_eq("occupied_turn", 64'(turn),         64'd1);
    idle();
    check_eq("ill_pulse_end", 64'(illegal_move), 64'd0);
    step(1'b0, 1'b1, 1'b0, 0, 12);
    check_eq("range_ill",     64'(illegal_move), 64'd1);
    check_eq("range_turn",    64'(turn),         64'd1);
    idle();

    start_game();
    pmove(0); cmove(1); pmove(2); cmove(4); pmove(3);
    cmove(5); pmove(7); cmove(6); pmove(8);
    check_eq("draw_who",   64'(who),        64'd3);
    check_eq("draw_count", 64'(draws),      64'd1);
    check_eq("draw_mc",    64'(move_count), 64'd9);

    start_game();
    pmove(0); cmove(4);
    saved_pw = player_wins;
    step(1'b1, 1'b0, 1'b1, 5, 0);
    check_eq("ng_board", 64'(board),       64'd0);
    check_eq("ng_mc",    64'(move_count),  64'd0);
    check_eq("ng_pw",    64'(player_wins), 64'(saved_pw));

    repeat (4) row_win_game();
    check_eq("pw_saturated", 64'(player_wins), 64'(TMAX));

    start_game();
    pmove(0);
    step(1'b0, 1'b1, 1'b0, 0, 4);
    pc = 1'b0;
    #1 reset = 1'b0;
    #1 model_reset();
    compare_all();
    #1 reset = 1'b1;
    @(negedge clock);
    compare_all();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    cell0 = board[1:0];
    check_eq("post_reset_cell0", 64'(cell0), 64'd1);
    idle();

    repeat (3000) begin
      bit ng, p, c;
      int pp, cp;
      ng = ($urandom % 40) == 0;
      p  = ($urandom % 4) != 0;
      c  = ($urandom % 4) != 0;
      pp = ($urandom % 16 < 13) ? int'($urandom % CELLS) : int'($urandom % 16);
      cp = ($urandom % 16 < 13) ? int'($urandom % CELLS) : int'($urandom % 16);
      step(p, c, ng, pp, cp);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
